// File: rtl/register_file_ext_pkg.sv
// Shared types and helpers for the multi-port register file.
package register_file_ext_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   function automatic int unsigned strb_width(input int unsigned data_width,
                                              input int unsigned byte_width);
      return data_width / byte_width;
   endfunction

endpackage

// File: rtl/register_file_bank.sv
// Storage array with one byte-strobed synchronous write port and N combinational read ports.
module register_file_bank
   import register_file_ext_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BYTE_WIDTH = 8,
   parameter int unsigned READ_PORTS = 2
) (
   input  logic                                  clk_i,
   input  logic                                  write_en_i,
   input  logic [ADDR_WIDTH-1:0]                 write_address_i,
   input  logic [DATA_WIDTH-1:0]                 write_data_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      write_strb_i,
   input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] read_address_i,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] read_data_o
);

   localparam int unsigned DEPTH      = 1 << ADDR_WIDTH;
   localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH, BYTE_WIDTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Contents are intentionally not reset; the clear sequencer defines them.
   always_ff @(posedge clk_i) begin
      if (write_en_i) begin
         for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
            if (write_strb_i[b]) begin
               mem[write_address_i][b*BYTE_WIDTH +: BYTE_WIDTH] <=
                  write_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   always_comb begin
      for (int unsigned p = 0; p < READ_PORTS; p++) begin
         read_data_o[p] = mem[read_address_i[p]];
      end
   end

endmodule

// File: rtl/register_file_ext.sv
// Multi-read-port register file with strobed writes, optional registered reads
// with write-first bypass, and a sequencer that clears every entry after reset.
module register_file_ext
   import register_file_ext_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH      = 4,
   parameter int unsigned           DATA_WIDTH      = 32,
   parameter int unsigned           BYTE_WIDTH      = 8,
   parameter int unsigned           READ_PORTS      = 2,
   parameter bit                    REGISTERED_READ = 1'b1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE     = '0
) (
   input  logic                                  clk_i,
   input  logic                                  rst_ni,
   input  logic                                  clear_i,
   output logic                                  busy_o,
   input  logic                                  write_en_i,
   input  logic [ADDR_WIDTH-1:0]                 write_address_i,
   input  logic [DATA_WIDTH-1:0]                 write_data_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]      write_strb_i,
   output logic                                  write_dropped_o,
   input  logic [READ_PORTS-1:0]                 read_en_i,
   input  logic [READ_PORTS-1:0][ADDR_WIDTH-1:0] read_address_i,
   output logic [READ_PORTS-1:0][DATA_WIDTH-1:0] read_data_o,
   output logic [READ_PORTS-1:0]                 read_valid_o
);

   localparam int unsigned          STRB_WIDTH = strb_width(DATA_WIDTH, BYTE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   if ((DATA_WIDTH % BYTE_WIDTH) != 0 || READ_PORTS < 1) begin : g_bad_cfg
      $error("register_file_ext: DATA_WIDTH must be a multiple of BYTE_WIDTH and READ_PORTS >= 1");
   end

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clear_cnt;
   logic                    write_accept_c;
   logic                    bank_we_c;
   logic [ADDR_WIDTH-1:0]   bank_addr_c;
   logic [DATA_WIDTH-1:0]   bank_data_c;
   logic [STRB_WIDTH-1:0]   bank_strb_c;
   logic [READ_PORTS-1:0][DATA_WIDTH-1:0] bank_rdata;

   assign busy_o         = (state == CLEAR);
   assign write_accept_c = (state == IDLE) && !clear_i && write_en_i;

   // Clear sequencer owns the write port while busy.
   always_comb begin
      bank_we_c   = write_accept_c;
      bank_addr_c = write_address_i;
      bank_data_c = write_data_i;
      bank_strb_c = write_strb_i;
      if (state == CLEAR) begin
         bank_we_c   = 1'b1;
         bank_addr_c = clear_cnt;
         bank_data_c = CLEAR_VALUE;
         bank_strb_c = '1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state           <= CLEAR;
         clear_cnt       <= '0;
         write_dropped_o <= 1'b0;
      end else begin
         write_dropped_o <= write_en_i && (busy_o || clear_i);
         case (state)
            CLEAR: begin
               clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
               if (clear_cnt == LAST_ADDR) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (clear_i) begin
                  state     <= CLEAR;
                  clear_cnt <= '0;
               end
            end
         endcase
      end
   end

   register_file_bank #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BYTE_WIDTH (BYTE_WIDTH),
      .READ_PORTS (READ_PORTS)
   ) u_bank (
      .clk_i           (clk_i),
      .write_en_i      (bank_we_c),
      .write_address_i (bank_addr_c),
      .write_data_i    (bank_data_c),
      .write_strb_i    (bank_strb_c),
      .read_address_i  (read_address_i),
      .read_data_o     (bank_rdata)
   );

   if (REGISTERED_READ) begin : g_reg_read
      logic [READ_PORTS-1:0][DATA_WIDTH-1:0] bypass_c;

      // Write-first: merge this cycle's accepted write into a colliding read.
      always_comb begin
         for (int unsigned p = 0; p < READ_PORTS; p++) begin
            bypass_c[p] = bank_rdata[p];
            if (write_accept_c && (write_address_i == read_address_i[p])) begin
               for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                  if (write_strb_i[b]) begin
                     bypass_c[p][b*BYTE_WIDTH +: BYTE_WIDTH] =
                        write_data_i[b*BYTE_WIDTH +: BYTE_WIDTH];
                  end
               end
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            read_data_o  <= '0;
            read_valid_o <= '0;
         end else begin
            for (int unsigned p = 0; p < READ_PORTS; p++) begin
               read_valid_o[p] <= read_en_i[p] && !busy_o;
               if (read_en_i[p] && !busy_o) begin
                  read_data_o[p] <= bypass_c[p];
               end
            end
         end
      end
   end else begin : g_comb_read
      assign read_data_o  = bank_rdata;
      assign read_valid_o = read_en_i & {READ_PORTS{!busy_o}};
   end

endmodule

// File: doc/register_file_ext.md
# register_file_ext

Parametrised multi-read-port register file with byte-strobed writes, selectable registered or combinational reads, and a hardware clear sequencer. It is the general-purpose storage block for FIFOs, CPU register banks and lookup tables in the design. It replaces ad-hoc single-port arrays wherever deterministic post-reset contents or more than one read port is needed.

## Interface
- ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- BYTE_WIDTH, 8, bits per write strobe
- READ_PORTS, 2, number of independent read ports (≥1)
- REGISTERED_READ, 1, 1 = synchronous read with write-first bypass; 0 = combinational read
- CLEAR_VALUE, '0, word written to every entry by the clear sequencer
- clk_i  in  1  single clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- clear_i  in  1  request a full clear (sampled only in IDLE)
- busy_o  out  1  clear sequence in progress
- write_en_i  in  1  write request
- write_address_i  in  ADDR_WIDTH  write address
- write_data_i  in  DATA_WIDTH  write data
- write_strb_i  in  DATA_WIDTH/BYTE_WIDTH  per-byte write enable
- write_dropped_o  out  1  one-cycle pulse: write request was discarded
- read_en_i  in  READ_PORTS  per-port read request
- read_address_i  in  READ_PORTS×ADDR_WIDTH  per-port read address
- read_data_o  out  READ_PORTS×DATA_WIDTH  per-port read data
- read_valid_o  out  READ_PORTS  per-port read data valid

## Operation
- FSM states: CLEAR, IDLE. Reset → CLEAR with clear counter = 0.
- CLEAR: each cycle writes CLEAR_VALUE (all bytes) to address = counter, then increments it; after writing address 2**ADDR_WIDTH-1 → IDLE. busy_o = 1 throughout CLEAR.
- IDLE: clear_i = 1 → CLEAR, counter = 0. Otherwise stay.
- Write: in IDLE with clear_i = 0, write_en_i = 1 updates bytes i of write_address_i where write_strb_i[i] = 1; other bytes keep their value. write_strb_i = 0 performs no update and is not a drop.
- write_dropped_o pulses the cycle after write_en_i = 1 is seen while busy_o = 1 or coincident with an accepted clear_i (clear wins).
- clear_i while busy_o = 1 is ignored; the sequence does not restart.
- Reads with REGISTERED_READ = 1: at the clock edge where read_en_i[p] = 1 and busy_o = 0, read_data_o[p] is loaded and read_valid_o[p] = 1 for the following cycle. If the same edge writes the same address, the loaded word is the post-write value (strobe-merged). With read_en_i[p] = 0, read_data_o[p] holds and read_valid_o[p] = 0.
- Reads with REGISTERED_READ = 0: read_data_o[p] = array[read_address_i[p]] combinationally (pre-write value on a same-cycle collision); read_valid_o[p] = read_en_i[p] & ~busy_o.
- Reads requested while busy_o = 1: read_valid_o = 0; data unspecified.
- All read ports are independent; identical addresses on several ports are legal.

## Timing
- Reset values: busy_o = 1, write_dropped_o = 0, read_valid_o = 0, read_data_o = 0 (registered mode). Storage array is not reset; its content is defined only after the clear completes.
- Clear duration: exactly 2**ADDR_WIDTH cycles; busy_o falls on the edge after the last entry is written. First accepted write: the first cycle busy_o = 0.
- Reset asserted mid-clear: sequence restarts from address 0 after release.
- Write latency: 1 edge. Registered read latency: 1 edge; combinational read: 0.
- Counter wraps only through the CLEAR→IDLE transition; no overflow is possible.

## Structure
- Package register_file_ext_pkg: state_t enum {CLEAR, IDLE}; function for strobe width (DATA_WIDTH/BYTE_WIDTH).
- Sub-module register_file_bank: storage array, strobed synchronous write port, READ_PORTS combinational read ports. Top level holds FSM, clear counter, write/clear mux, read registers and bypass.
- Elaboration-time assertion: DATA_WIDTH % BYTE_WIDTH == 0, READ_PORTS ≥ 1.

## Test plan
- Reset release, ADDR_WIDTH = 4: busy_o high 16 cycles, then all 16 entries read CLEAR_VALUE on both ports.
- Write 0xAABBCCDD to addr 3 strb 4'b1111, then 0x11223344 strb 4'b0101 → read addr 3 returns 0xAA22CC44 one cycle after read_en.
- REGISTERED_READ = 1, write 0x12345678 to addr 5 while port 0 reads addr 5 same cycle → read_data_o[0] = 0x12345678; with REGISTERED_READ = 0 the old value appears.
- clear_i and write_en_i same IDLE cycle → write_dropped_o pulses, busy_o high 16 cycles, address unchanged at CLEAR_VALUE; clear_i asserted again mid-clear → still 16 cycles total.
- Port 0 and port 1 read addrs 2 and 9 simultaneously with distinct content → both correct in the same cycle; read during busy → read_valid_o = 0.
- rst_ni pulsed low at clear cycle 7 → busy_o stays high, full 16-cycle clear after release.
